// File: rtl/drum_step_scheduler.sv
// drum_step_scheduler
// Sequences one node_grid timestep at a time: holds the grid in reset after a
// pluck, enables row sequencing for column_size rows plus the pipeline drain,
// captures the center-node amplitude and offers it to the audio path over a
// valid/ready handshake. Audio backpressure stalls the simulation; pluck and
// stop requests arriving mid-step are parked until the sample is accepted so
// the grid is never disturbed in the middle of a timestep.
module drum_step_scheduler #(
    parameter int unsigned PIPE_LAT    = 3,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MAX_STEPS   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pluck_req,
    input  logic               stop_req,
    input  logic [8:0]         column_size,
    input  logic signed [17:0] center_node_amp,
    output logic               grid_reset,
    output logic               grid_run,
    output logic signed [15:0] sample_data,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy,
    output logic [15:0]        step_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUTPUT  = 3'd4
    } state_t;

    // Counter preloads are "cycles minus one" so the state exits when the
    // counter reads zero.
    localparam logic [9:0]  INIT_LOAD   = 10'(INIT_CYCLES - 1);
    localparam logic [9:0]  PIPE_LAT_W  = 10'(PIPE_LAT);
    localparam logic [15:0] MAX_STEPS_W = 16'(MAX_STEPS);
    localparam bit          FREE_RUN    = (MAX_STEPS == 32'd0);

    // A zero-row column is meaningless to the grid; run it as a single row.
    function automatic logic [8:0] clamp_col(input logic [8:0] col);
        if (col == 9'd0) begin
            return 9'd1;
        end else begin
            return col;
        end
    endfunction

    state_t             state_r, state_s;
    logic [9:0]         cnt_r, cnt_s;
    logic [8:0]         col_q_r, col_s;
    logic               pend_pluck_r, pend_pluck_s;
    logic               pend_stop_r, pend_stop_s;
    logic [15:0]        step_count_r, step_s;
    logic signed [15:0] sample_data_r, data_s;
    logic               grid_reset_r, grid_run_r, sample_valid_r, busy_r;
    logic [9:0]         run_load_s;
    logic               max_hit_s;

    assign run_load_s = {1'b0, col_q_r} + PIPE_LAT_W - 10'd1;
    assign max_hit_s  = (!FREE_RUN) && (step_count_r == MAX_STEPS_W);

    // Next-state, counter, pending-request and capture logic.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        col_s        = col_q_r;
        step_s       = step_count_r;
        data_s       = sample_data_r;
        if (state_r != ST_IDLE) begin
            pend_pluck_s = pend_pluck_r | pluck_req;
            pend_stop_s  = pend_stop_r | stop_req;
        end else begin
            pend_pluck_s = 1'b0;
            pend_stop_s  = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (pluck_req) begin
                    state_s = ST_INIT;
                    col_s   = clamp_col(column_size);
                    step_s  = 16'd0;
                    cnt_s   = INIT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                if (cnt_r == 10'd0) begin
                    state_s = ST_RUN;
                    cnt_s   = run_load_s;
                end else begin
                    cnt_s = cnt_r - 10'd1;
                end
            end
            ST_RUN: begin
                if (cnt_r == 10'd0) begin
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s = cnt_r - 10'd1;
                end
            end
            ST_CAPTURE: begin
                // Arithmetic shift then narrow keeps bits [17:2]: truncation toward -inf.
                data_s  = 16'(center_node_amp >>> 2'd2);
                step_s  = step_count_r + 16'd1;
                state_s = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (sample_ready) begin
                    if (pend_pluck_s) begin
                        state_s      = ST_INIT;
                        col_s        = clamp_col(column_size);
                        step_s       = 16'd0;
                        cnt_s        = INIT_LOAD;
                        pend_pluck_s = 1'b0;
                        pend_stop_s  = 1'b0;
                    end else if (pend_stop_s || max_hit_s) begin
                        state_s      = ST_IDLE;
                        pend_pluck_s = 1'b0;
                        pend_stop_s  = 1'b0;
                    end else begin
                        state_s = ST_RUN;
                        cnt_s   = run_load_s;
                    end
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                pend_pluck_s = 1'b0;
                pend_stop_s  = 1'b0;
            end
        endcase
    end

    // State, datapath registers and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 10'd0;
            col_q_r        <= 9'd1;
            pend_pluck_r   <= 1'b0;
            pend_stop_r    <= 1'b0;
            step_count_r   <= 16'd0;
            sample_data_r  <= 16'sd0;
            grid_reset_r   <= 1'b1;
            grid_run_r     <= 1'b0;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            col_q_r        <= col_s;
            pend_pluck_r   <= pend_pluck_s;
            pend_stop_r    <= pend_stop_s;
            step_count_r   <= step_s;
            sample_data_r  <= data_s;
            grid_reset_r   <= (state_s == ST_IDLE) || (state_s == ST_INIT);
            grid_run_r     <= (state_s == ST_RUN);
            sample_valid_r <= (state_s == ST_OUTPUT);
            busy_r         <= (state_s != ST_IDLE);
        end
    end

    assign grid_reset   = grid_reset_r;
    assign grid_run     = grid_run_r;
    assign sample_data  = sample_data_r;
    assign sample_valid = sample_valid_r;
    assign busy         = busy_r;
    assign step_count   = step_count_r;

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Testbench for drum_step_scheduler: directed scenarios plus randomized traffic
// checked against a step-level behavioural model of the scheduler.
module tb_drum_step_scheduler;

    localparam int PIPE_LAT    = 3;
    localparam int INIT_CYCLES = 4;
    localparam int MAX_STEPS   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        pluck_req, stop_req, sample_ready;
    logic [8:0]  column_size;
    logic [17:0] center_node_amp;
    logic        grid_reset, grid_run, sample_valid, busy;
    logic [15:0] sample_data, step_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: position inside the current timestep.
    bit          m_busy;
    int          m_init_left;   // INIT cycles still to go (0 = stepping)
    int          m_pos;         // 0..len-1 running, len capture, len+1 output
    int          m_len;         // rows + pipeline drain
    bit          m_pp, m_ps;
    int          m_cnt;
    logic [15:0] m_data;

    drum_step_scheduler #(
        .PIPE_LAT   (PIPE_LAT),
        .INIT_CYCLES(INIT_CYCLES),
        .MAX_STEPS  (MAX_STEPS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pluck_req      (pluck_req),
        .stop_req       (stop_req),
        .column_size    (column_size),
        .center_node_amp(center_node_amp),
        .grid_reset     (grid_reset),
        .grid_run       (grid_run),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .busy           (busy),
        .step_count     (step_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 1'b0; m_init_left = 0; m_pos = 0; m_len = 0;
        m_pp = 1'b0; m_ps = 1'b0; m_cnt = 0; m_data = 16'h0000;
    endtask

    task automatic model_start();
        m_init_left = INIT_CYCLES;
        m_len = ((column_size == 9'd0) ? 1 : int'(column_size)) + PIPE_LAT;
        m_cnt = 0; m_pp = 1'b0; m_ps = 1'b0;
    endtask

    task automatic model_edge();
        logic signed [17:0] a_t;
        if (!m_busy) begin
            if (pluck_req) begin
                m_busy = 1'b1;
                model_start();
            end
        end else begin
            if (pluck_req) m_pp = 1'b1;
            if (stop_req)  m_ps = 1'b1;
            if (m_init_left > 0) begin
                m_init_left--;
                m_pos = 0;
            end else if (m_pos < m_len) begin
                m_pos++;
            end else if (m_pos == m_len) begin
                a_t = $signed(center_node_amp);
                a_t = a_t >>> 2;
                m_data = a_t[15:0];
                m_cnt = (m_cnt + 1) % 65536;
                m_pos++;
            end else if (sample_ready) begin
                if (m_pp) begin
                    model_start();
                end else if (m_ps || (MAX_STEPS != 0 && m_cnt == MAX_STEPS)) begin
                    m_busy = 1'b0; m_pp = 1'b0; m_ps = 1'b0;
                end else begin
                    m_pos = 0;
                end
            end
        end
    endtask

    function automatic logic [35:0] exp_vec();
        logic gr, gru, gv;
        gr  = !m_busy || (m_init_left > 0);
        gru = m_busy && (m_init_left == 0) && (m_pos < m_len);
        gv  = m_busy && (m_init_left == 0) && (m_pos == m_len + 1);
        return {gr, gru, gv, m_busy, 16'(m_cnt), m_data};
    endfunction

    // One clock: advance the model at the edge, then settle past it.
    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pluck_req = 1'b0; stop_req = 1'b0; sample_ready = 1'b0;
        column_size = 9'd0; center_node_amp = 18'h0;
        model_reset();
        cyc(); cyc(); cyc();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_checks++;
            if ({grid_reset, grid_run, sample_valid, busy, step_count, sample_data}
                !== {1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got %b%b%b%b sc=%h sd=%h, expected 1000 sc=0000 sd=0000",
                         i, grid_reset, grid_run, sample_valid, busy, step_count, sample_data);
            end
        end
    endtask

    task automatic test_timestep();
        int init_len, run_len, samples, last_rise;
        column_size = 9'd30; center_node_amp = 18'h10000; sample_ready = 1'b1;
        pluck_req = 1'b1; cyc(); pluck_req = 1'b0;
        init_len = 0; run_len = 0; samples = 0; last_rise = -1;
        for (int c = 0; c < 300 && samples < 3; c++) begin
            if (busy && grid_reset) init_len++;
            if (grid_run) run_len++;
            else if (run_len != 0) begin
                n_checks++;
                if (run_len !== 33) begin
                    n_fail++;
                    $display("FAIL run_len: got %0d, expected 33", run_len);
                end
                run_len = 0;
            end
            if (sample_valid) begin
                n_checks++;
                if ({sample_data, step_count} !== {16'h4000, 16'(samples + 1)}) begin
                    n_fail++;
                    $display("FAIL sample: got data=%h sc=%0d, expected data=4000 sc=%0d",
                             sample_data, step_count, samples + 1);
                end
                if (last_rise >= 0) begin
                    n_checks++;
                    if (c - last_rise !== 35) begin
                        n_fail++;
                        $display("FAIL period: got %0d, expected 35", c - last_rise);
                    end
                end
                last_rise = c;
                samples++;
            end
            cyc();
        end
        n_checks++;
        if (init_len !== INIT_CYCLES) begin
            n_fail++;
            $display("FAIL init_len: got %0d, expected %0d", init_len, INIT_CYCLES);
        end
        n_checks++;
        if (samples !== 3) begin
            n_fail++;
            $display("FAIL timestep_samples: got %0d, expected 3", samples);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        bit bad;
        sample_ready = 1'b0;
        for (int c = 0; c < 200 && !sample_valid; c++) cyc();
        n_checks++;
        if ({sample_valid, sample_data, step_count} !== {1'b1, 16'h4000, 16'd4}) begin
            n_fail++;
            $display("FAIL bp_first: got v=%b d=%h sc=%0d, expected v=1 d=4000 sc=4",
                     sample_valid, sample_data, step_count);
        end
        held = sample_data; bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (!sample_valid || sample_data !== held || grid_run) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got disturbance=%b, expected 0", bad);
        end
        sample_ready = 1'b1;
        cyc();
        n_checks++;
        if ({sample_valid, grid_run, step_count} !== {1'b0, 1'b1, 16'd4}) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b run=%b sc=%0d, expected v=0 run=1 sc=4",
                     sample_valid, grid_run, step_count);
        end
    endtask

    task automatic test_mid_pluck();
        bit bad;
        for (int i = 0; i < 9; i++) cyc();
        pluck_req = 1'b1; cyc(); pluck_req = 1'b0;
        center_node_amp = 18'h3FFFD;
        bad = 1'b0;
        for (int c = 0; c < 200 && !sample_valid; c++) begin
            if (grid_reset) bad = 1'b1;
            cyc();
        end
        n_checks++;
        if ({sample_valid, bad, step_count, sample_data} !== {1'b1, 1'b0, 16'd5, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL mid_pluck_sample: got v=%b rst_seen=%b sc=%0d d=%h, expected v=1 rst_seen=0 sc=5 d=ffff",
                     sample_valid, bad, step_count, sample_data);
        end
        cyc();
        n_checks++;
        if ({busy, grid_reset, grid_run, sample_valid, step_count} !== {4'b1100, 16'd0}) begin
            n_fail++;
            $display("FAIL mid_pluck_init: got b=%b gr=%b run=%b v=%b sc=%0d, expected b=1 gr=1 run=0 v=0 sc=0",
                     busy, grid_reset, grid_run, sample_valid, step_count);
        end
    endtask

    task automatic test_max_steps();
        int samples, run_len, first_run, rl;
        column_size = 9'd7; sample_ready = 1'b1; center_node_amp = 18'h08004;
        samples = 0; run_len = 0; first_run = -1;
        for (int c = 0; c < 1000 && busy; c++) begin
            if (grid_run) run_len++;
            else if (run_len != 0) begin
                if (first_run < 0) first_run = run_len;
                run_len = 0;
            end
            if (sample_valid) samples++;
            cyc();
        end
        n_checks++;
        if (first_run !== 33) begin
            n_fail++;
            $display("FAIL latched_col_run: got %0d, expected 33", first_run);
        end
        n_checks++;
        if ({samples[7:0], busy, grid_reset, sample_valid, step_count, sample_data}
            !== {8'd5, 3'b010, 16'd5, 16'h2001}) begin
            n_fail++;
            $display("FAIL max_steps: got n=%0d b=%b gr=%b v=%b sc=%0d d=%h, expected n=5 b=0 gr=1 v=0 sc=5 d=2001",
                     samples, busy, grid_reset, sample_valid, step_count, sample_data);
        end
        // Pluck and stop together mid-RUN: pluck must win.
        pluck_req = 1'b1; cyc(); pluck_req = 1'b0;
        for (int c = 0; c < 200 && !grid_run; c++) cyc();
        pluck_req = 1'b1; stop_req = 1'b1; cyc(); pluck_req = 1'b0; stop_req = 1'b0;
        for (int c = 0; c < 200 && !sample_valid; c++) cyc();
        n_checks++;
        if ({sample_valid, step_count} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL both_sample: got v=%b sc=%0d, expected v=1 sc=1", sample_valid, step_count);
        end
        cyc();
        n_checks++;
        if ({busy, grid_reset, sample_valid, step_count} !== {3'b110, 16'd0}) begin
            n_fail++;
            $display("FAIL both_pluck_wins: got b=%b gr=%b v=%b sc=%0d, expected b=1 gr=1 v=0 sc=0",
                     busy, grid_reset, sample_valid, step_count);
        end
        rl = 0;
        for (int c = 0; c < 200 && !sample_valid; c++) begin
            if (grid_run) rl++;
            cyc();
        end
        n_checks++;
        if ({sample_valid, step_count, 16'(rl)} !== {1'b1, 16'd1, 16'd10}) begin
            n_fail++;
            $display("FAIL both_continue: got v=%b sc=%0d run=%0d, expected v=1 sc=1 run=10",
                     sample_valid, step_count, rl);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 3000 && errs < 10; c++) begin
            pluck_req       = ($urandom_range(0, 39) == 0);
            stop_req        = ($urandom_range(0, 59) == 0);
            sample_ready    = ($urandom_range(0, 9) < 7);
            column_size     = 9'($urandom_range(0, 20));
            center_node_amp = 18'($urandom);
            cyc();
            n_checks++;
            if ({grid_reset, grid_run, sample_valid, busy, step_count, sample_data} !== exp_vec()) begin
                n_fail++; errs++;
                $display("FAIL random cyc %0d: got %h, expected %h", c,
                         {grid_reset, grid_run, sample_valid, busy, step_count, sample_data}, exp_vec());
            end
        end
        pluck_req = 1'b0; stop_req = 1'b0;
    endtask

    task automatic test_async_reset();
        if (!busy) begin
            column_size = 9'd4; pluck_req = 1'b1; cyc(); pluck_req = 1'b0;
        end
        sample_ready = 1'b0; center_node_amp = 18'h1F00F;
        for (int c = 0; c < 600 && !sample_valid; c++) cyc();
        n_checks++;
        if (sample_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_setup: got v=%b, expected v=1", sample_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({grid_reset, grid_run, sample_valid, busy, step_count, sample_data}
            !== {4'b1000, 16'd0, 16'd0}) begin
            n_fail++;
            $display("FAIL areset_async: got %b%b%b%b sc=%h d=%h, expected 1000 sc=0000 d=0000",
                     grid_reset, grid_run, sample_valid, busy, step_count, sample_data);
        end
        cyc(); cyc();
        reset = 1'b1; sample_ready = 1'b1; column_size = 9'd2;
        pluck_req = 1'b1; cyc(); pluck_req = 1'b0;
        for (int c = 0; c < 60; c++) begin
            center_node_amp = 18'($urandom);
            cyc();
            n_checks++;
            if ({grid_reset, grid_run, sample_valid, busy, step_count, sample_data} !== exp_vec()) begin
                n_fail++;
                $display("FAIL areset_recover cyc %0d: got %h, expected %h", c,
                         {grid_reset, grid_run, sample_valid, busy, step_count, sample_data}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_timestep();
        test_backpressure();
        test_mid_pluck();
        test_max_steps();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
